pin_debounce: RTL and testbench
===============================

// Module: pin_debounce
// PURPOSE
//  Board-pin input conditioner for iCE40 designs: synchronises WIDTH raw
//  header pins (e.g. J1) to CLK and debounces each bit independently.
//  Sits directly upstream of the per-bit logic stages (inverters, gates)
//  that drive the output header. Their input bus connects to O.
// PARAMETERS
//  WIDTH          3      number of independent pin bits
//  CNT_W          16     debounce counter width; must satisfy 2**CNT_W >= STABLE_CYCLES
//  STABLE_CYCLES  12000  cycles a new level must persist (1 ms at 12 MHz); >= 1
//  RESET_VAL      0      WIDTH-bit value loaded into sync FFs and O on reset
// PORTS
//  CLK          in   1      single clock, rising edge
//  ASYNCRESETN  in   1      asynchronous, active-low reset
//  I            in   WIDTH  raw asynchronous pin inputs
//  O            out  WIDTH  debounced, registered level per bit
//  RISE         out  WIDTH  1-cycle pulse on O[i] 0->1 (PIN_DEBOUNCE_EDGE_EN only)
//  FALL         out  WIDTH  1-cycle pulse on O[i] 1->0 (PIN_DEBOUNCE_EDGE_EN only)
// BEHAVIOUR
//  - Reset (ASYNCRESETN=0, acts immediately): s1, s2, O = RESET_VAL; all counters = 0;
//    RISE/FALL = 0. Reset mid-debounce discards pending counts; no O update follows.
//  - Sync: 2-FF chain per bit, s1 <= I, s2 <= s1. No logic between the FFs.
//  - Per-bit FSM, state implied by (s2 != O): STABLE (equal, cnt held 0) /
//    PENDING (differ). Each edge:
//      s2 == O                          : cnt <= 0 (glitch abandoned, O held)
//      s2 != O, cnt <  STABLE_CYCLES-1  : cnt <= cnt+1
//      s2 != O, cnt == STABLE_CYCLES-1  : O <= s2, cnt <= 0
//  - Latency: a clean level change on I appears on O exactly STABLE_CYCLES+2
//    edges after the first sampling edge.
//  - Filtering: level held >= STABLE_CYCLES cycles at s2 passes. Shorter levels
//    (<= STABLE_CYCLES-1) never reach O. Bits are fully independent.
//  - STABLE_CYCLES == 1: O follows s2 one edge later (3-edge latency).
//  - Counter never wraps: it clears at the terminal count, so CNT_W overflow
//    is impossible given the parameter rule.
//  - All outputs are registered; no combinational path from I to O.
// CONFIGURATION
//  Macro PIN_DEBOUNCE_EDGE_EN:
//    defined   -> RISE/FALL ports exist. Registered, asserted on the same edge
//                 O changes, for exactly one cycle. Reset value 0.
//    undefined -> RISE/FALL ports and their logic are absent; O is unaffected.
// STRUCTURE
//  - Shared package pin_io_pkg:
//    - PIN_W default (3)
//    - DEBOUNCE_1MS_12MHZ = 12000
//    - a typedef for the per-bit debounce state enum {STABLE, PENDING}
//  - Sub-module debounce_bit (one bit: 2-FF sync, counter, O/edge registers).
//    The top instantiates WIDTH copies via generate.
// TESTING  (bench uses STABLE_CYCLES=4, WIDTH=3, RESET_VAL=3'b000)
//  1 Reset: hold ASYNCRESETN=0 with I=3'b111 -> O=000, RISE=FALL=000; release
//    -> O=3'b111 exactly 6 edges after the first post-reset edge.
//  2 Clean step: I 000->101 between edges -> O=101 on edge 6 (not 5).
//    RISE=101 for that cycle only.
//  3 Glitch: I[1]=1 for 3 cycles then 0 -> O[1] stays 0, RISE stays 000.
//    Repeat with 4 cycles -> O[1] pulses 1 for 4 cycles.
//  4 Bounce: I[0] toggles 1,0,1,0,1 (1 cycle each) then holds 1
//    -> O[0] rises 6 edges after the final 0->1, exactly once.
//  5 Independence: I[0] rises while I[2] falls in the same cycle (O=3'b100)
//    -> O=3'b001 on edge 6. RISE=001 and FALL=100 in the same cycle.
//  6 Async reset mid-PENDING: assert ASYNCRESETN=0 between edges at cnt=2
//    -> O=000 immediately. After release with I held, the full 6-edge latency
//    restarts.

Source files
------------

// File: rtl/pin_io_pkg.sv
// Shared pin-conditioning definitions: default bus width, the 1 ms debounce
// constant for a 12 MHz board clock, and the per-bit debounce state type.
package pin_io_pkg;

    localparam int PIN_W              = 3;
    localparam int DEBOUNCE_1MS_12MHZ = 12000;

    // STABLE: synced level matches the output. PENDING: a new level is being timed.
    typedef enum logic {
        STABLE  = 1'b0,
        PENDING = 1'b1
    } db_state_e;

endpackage

// File: rtl/pin_debounce_if.sv
// Pin conditioner bundle: raw pins in, debounced levels (and optional edge
// pulses when PIN_DEBOUNCE_EDGE_EN is defined) out.
interface pin_debounce_if
    import pin_io_pkg::*;
#(
    parameter int WIDTH = PIN_W
);
    logic [WIDTH-1:0] I;
    logic [WIDTH-1:0] O;
`ifdef PIN_DEBOUNCE_EDGE_EN
    logic [WIDTH-1:0] RISE;
    logic [WIDTH-1:0] FALL;

    modport master (output I, input  O, input  RISE, input  FALL);
    modport slave  (input  I, output O, output RISE, output FALL);
`else
    modport master (output I, input  O);
    modport slave  (input  I, output O);
`endif
endinterface

// File: rtl/debounce_bit.sv
// One pin bit: 2-FF synchroniser, stability counter and registered output.
// Optional registered edge pulses when PIN_DEBOUNCE_EDGE_EN is defined.
// The caller guarantees 2**CNT_W >= STABLE_CYCLES and STABLE_CYCLES >= 1.
module debounce_bit
    import pin_io_pkg::*;
#(
    parameter int   CNT_W         = 16,
    parameter int   STABLE_CYCLES = DEBOUNCE_1MS_12MHZ,
    parameter logic RESET_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
`ifdef PIN_DEBOUNCE_EDGE_EN
    ,
    output logic rise_o,
    output logic fall_o
`endif
);

    // Counter value on the edge where the new level has persisted long enough.
    localparam logic [CNT_W-1:0] TERM = CNT_W'(STABLE_CYCLES - 1);

    logic             s1_q, s2_q;
    logic             o_q, o_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    db_state_e        state;
`ifdef PIN_DEBOUNCE_EDGE_EN
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
`endif

    // Synchroniser chain, plain FF to FF.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= RESET_VAL;
            s2_q <= RESET_VAL;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    // Debounce state registers; reset discards any pending count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_q    <= RESET_VAL;
            cnt_q  <= '0;
`ifdef PIN_DEBOUNCE_EDGE_EN
            rise_q <= 1'b0;
            fall_q <= 1'b0;
`endif
        end else begin
            o_q    <= o_d;
            cnt_q  <= cnt_d;
`ifdef PIN_DEBOUNCE_EDGE_EN
            rise_q <= rise_d;
            fall_q <= fall_d;
`endif
        end
    end

    // Next-state: time a differing level, commit it at the terminal count.
    // The counter clears on commit, so it never wraps.
    always_comb begin
        state  = (s2_q != o_q) ? PENDING : STABLE;
        o_d    = o_q;
        cnt_d  = '0;
`ifdef PIN_DEBOUNCE_EDGE_EN
        rise_d = 1'b0;
        fall_d = 1'b0;
`endif
        case (state)
            STABLE:  cnt_d = '0;
            PENDING: begin
                if (cnt_q == TERM) begin
                    o_d    = s2_q;
                    cnt_d  = '0;
`ifdef PIN_DEBOUNCE_EDGE_EN
                    rise_d = s2_q;
                    fall_d = ~s2_q;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        endcase
    end

    assign q_o    = o_q;
`ifdef PIN_DEBOUNCE_EDGE_EN
    assign rise_o = rise_q;
    assign fall_o = fall_q;
`endif

endmodule

// File: rtl/pin_debounce.sv
// Board-pin conditioner: WIDTH independent synchronise+debounce bits.
// Define PIN_DEBOUNCE_EDGE_EN to add registered RISE/FALL pulse outputs.
module pin_debounce
    import pin_io_pkg::*;
#(
    parameter int               WIDTH         = PIN_W,
    parameter int               CNT_W         = 16,
    parameter int               STABLE_CYCLES = DEBOUNCE_1MS_12MHZ,
    parameter logic [WIDTH-1:0] RESET_VAL     = '0
) (
    input  logic             CLK,
    input  logic             ASYNCRESETN,
    input  logic [WIDTH-1:0] I,
    output logic [WIDTH-1:0] O
`ifdef PIN_DEBOUNCE_EDGE_EN
    ,
    output logic [WIDTH-1:0] RISE,
    output logic [WIDTH-1:0] FALL
`endif
);

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        debounce_bit #(
            .CNT_W         (CNT_W),
            .STABLE_CYCLES (STABLE_CYCLES),
            .RESET_VAL     (RESET_VAL[g])
        ) u_bit (
            .clk    (CLK),
            .rst_n  (ASYNCRESETN),
            .d_i    (I[g]),
            .q_o    (O[g])
`ifdef PIN_DEBOUNCE_EDGE_EN
            ,
            .rise_o (RISE[g]),
            .fall_o (FALL[g])
`endif
        );
    end

endmodule

// File: tb/tb_pin_debounce.sv
// Directed bench for pin_debounce (STABLE_CYCLES=4, WIDTH=3) plus a 1-bit
// STABLE_CYCLES=1 instance for the minimum-latency case.
module tb_pin_debounce;
    import pin_io_pkg::*;

    logic CLK = 1'b0;
    logic ASYNCRESETN;
    int   nvec = 0;
    int   nerr = 0;

    pin_debounce_if #(.WIDTH(3)) bus ();

    logic [0:0] i1, o1;
`ifdef PIN_DEBOUNCE_EDGE_EN
    logic [0:0] rise1, fall1;
`endif

    always #5 CLK = ~CLK;

    pin_debounce #(
        .WIDTH(3), .CNT_W(16), .STABLE_CYCLES(4), .RESET_VAL(3'b000)
    ) dut (
        .CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .I(bus.I), .O(bus.O)
`ifdef PIN_DEBOUNCE_EDGE_EN
        , .RISE(bus.RISE), .FALL(bus.FALL)
`endif
    );

    pin_debounce #(
        .WIDTH(1), .CNT_W(1), .STABLE_CYCLES(1), .RESET_VAL(1'b0)
    ) dut1 (
        .CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .I(i1), .O(o1)
`ifdef PIN_DEBOUNCE_EDGE_EN
        , .RISE(rise1), .FALL(fall1)
`endif
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic chk_edges(input string tag, input logic [2:0] r, input logic [2:0] f);
`ifdef PIN_DEBOUNCE_EDGE_EN
        chk({tag, ".rise"}, 8'(bus.RISE), 8'(r));
        chk({tag, ".fall"}, 8'(bus.FALL), 8'(f));
`else
        if (r !== r || f !== f) $display("unreachable");
`endif
    endtask

    initial begin
        ASYNCRESETN = 1'b0;
        bus.I       = 3'b111;
        i1          = 1'b0;

        // 1: reset holds outputs low while pins are high; 6-edge latency after release
        step(3);
        chk("rst.O", 8'(bus.O), 8'b000);
        chk_edges("rst", 3'b000, 3'b000);
        ASYNCRESETN = 1'b1;
        step(5);
        chk("rel.e5", 8'(bus.O), 8'b000);
        step(1);
        chk("rel.e6", 8'(bus.O), 8'b111);
        chk_edges("rel.e6", 3'b111, 3'b000);

        // 2: clean step 000 -> 101
        bus.I = 3'b000;
        step(6);
        chk("clr.e6", 8'(bus.O), 8'b000);
        chk_edges("clr.e6", 3'b000, 3'b111);
        step(2);
        bus.I = 3'b101;
        step(5);
        chk("step.e5", 8'(bus.O), 8'b000);
        step(1);
        chk("step.e6", 8'(bus.O), 8'b101);
        chk_edges("step.e6", 3'b101, 3'b000);
        step(1);
        chk("step.e7", 8'(bus.O), 8'b101);
        chk_edges("step.e7", 3'b000, 3'b000);

        // 3a: 3-cycle glitch on bit 1 is filtered
        bus.I = 3'b111;
        step(3);
        bus.I = 3'b101;
        for (int k = 0; k < 8; k++) begin
            step(1);
            chk("glitch3.O", 8'(bus.O), 8'b101);
            chk_edges("glitch3", 3'b000, 3'b000);
        end

        // 3b: 4-cycle level passes and is itself held for 4 cycles
        bus.I = 3'b111;
        step(4);
        bus.I = 3'b101;
        step(1);
        chk("pulse4.e5", 8'(bus.O), 8'b101);
        step(1);
        chk("pulse4.e6", 8'(bus.O), 8'b111);
        chk_edges("pulse4.e6", 3'b010, 3'b000);
        step(3);
        chk("pulse4.e9", 8'(bus.O), 8'b111);
        step(1);
        chk("pulse4.e10", 8'(bus.O), 8'b101);
        chk_edges("pulse4.e10", 3'b000, 3'b010);
        step(2);

        // 4: bounce on bit 0, then hold high
        bus.I = 3'b100;
        step(6);
        chk("b.pre", 8'(bus.O), 8'b100);
        step(2);
        bus.I = 3'b101; step(1); chk("b.1", 8'(bus.O), 8'b100);
        bus.I = 3'b100; step(1); chk("b.0", 8'(bus.O), 8'b100);
        bus.I = 3'b101; step(1); chk("b.1b", 8'(bus.O), 8'b100);
        bus.I = 3'b100; step(1); chk("b.0b", 8'(bus.O), 8'b100);
        bus.I = 3'b101;
        step(5);
        chk("b.e5", 8'(bus.O), 8'b100);
        step(1);
        chk("b.e6", 8'(bus.O), 8'b101);
        chk_edges("b.e6", 3'b001, 3'b000);
        for (int k = 0; k < 4; k++) begin
            step(1);
            chk("b.hold", 8'(bus.O), 8'b101);
            chk_edges("b.hold", 3'b000, 3'b000);
        end

        // 5: bit 0 rises while bit 2 falls
        bus.I = 3'b100;
        step(6);
        chk("ind.pre", 8'(bus.O), 8'b100);
        step(2);
        bus.I = 3'b001;
        step(5);
        chk("ind.e5", 8'(bus.O), 8'b100);
        step(1);
        chk("ind.e6", 8'(bus.O), 8'b001);
        chk_edges("ind.e6", 3'b001, 3'b100);

        // 6: async reset with counts at 2, then full latency restarts
        step(1);
        bus.I = 3'b110;
        step(4);
        #2;
        ASYNCRESETN = 1'b0;
        #1;
        chk("arst.O", 8'(bus.O), 8'b000);
        chk_edges("arst", 3'b000, 3'b000);
        step(2);
        chk("arst.hold", 8'(bus.O), 8'b000);
        ASYNCRESETN = 1'b1;
        step(5);
        chk("arst.e5", 8'(bus.O), 8'b000);
        step(1);
        chk("arst.e6", 8'(bus.O), 8'b110);

        // 7: STABLE_CYCLES=1 gives 3-edge latency
        i1 = 1'b1;
        step(2);
        chk("sc1.e2", 8'(o1), 8'b0);
        step(1);
        chk("sc1.e3", 8'(o1), 8'b1);
`ifdef PIN_DEBOUNCE_EDGE_EN
        chk("sc1.rise", 8'(rise1), 8'b1);
        chk("sc1.fall", 8'(fall1), 8'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
